// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
package piso_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

endpackage

// File: rtl/piso_tx.sv
// Serializes a WIDTH-bit word LSB first with valid/last framing and
// supports back-to-back words by reloading on the last-bit edge.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             so,
    output logic             so_valid,
    output logic             so_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    piso_state_e      state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Outputs depend on registered state only; load_valid never reaches them.
    assign so_last    = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    assign so_valid   = (state_q == SHIFT);
    assign so         = so_valid & sr_q[0];
    assign busy       = so_valid;
    assign load_ready = (state_q == IDLE) || so_last;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (load_valid) begin
                    state_d = SHIFT;
                    sr_d    = din;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (so_last) begin
                    cnt_d = '0;
                    if (load_valid) begin
                        sr_d = din;
                    end else begin
                        state_d = IDLE;
                        sr_d    = '0;
                    end
                end else begin
                    sr_d  = sr_q >> 1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                sr_d    = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Randomized and directed checks of piso_tx against a bit-queue reference model.
module tb_piso_tx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         load_valid;
    logic         load_ready, so, so_valid, so_last, busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: bits still owed on the wire; the front is what so shows now.
    bit           exp_q[$];
    logic [31:0]  obs;
    int           obs_n;
    logic [W-1:0] sipo;

    piso_tx #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .so         (so),
        .so_valid   (so_valid),
        .so_last    (so_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Receiver that shifts right with the serial bit entering at the MSB.
    always @(posedge clk) begin
        if (so_valid) sipo <= {so, sipo[W-1:1]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic lv, input logic [W-1:0] d);
        bit ready;
        @(negedge clk);
        chk("so_valid",   32'(so_valid),   32'(exp_q.size() != 0));
        chk("so",         32'(so),         32'(exp_q.size() != 0 ? exp_q[0] : 1'b0));
        chk("so_last",    32'(so_last),    32'(exp_q.size() == 1));
        chk("busy",       32'(busy),       32'(exp_q.size() != 0));
        chk("load_ready", 32'(load_ready), 32'(exp_q.size() <= 1));
        if (so_valid && obs_n < 32) begin
            obs[obs_n] = so;
            obs_n++;
        end
        rst        = r;
        load_valid = lv;
        din        = d;
        ready = (exp_q.size() <= 1);
        if (r) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (lv && ready)
                for (int i = 0; i < W; i++) exp_q.push_back(d[i]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0);
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; din = '0; sipo = '0;
        obs = '0; obs_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Single word
        obs = '0; obs_n = 0;
        cyc(1'b0, 1'b1, 4'b1011);
        idle(5);
        chk("single_n",    32'(obs_n), 32'd4);
        chk("single_bits", 32'(obs[3:0]), 32'b1011);
        chk("single_sipo", 32'(sipo), 32'b1011);

        // Back-to-back
        obs = '0; obs_n = 0;
        cyc(1'b0, 1'b1, 4'b0110);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 4'b1001);
        idle(9);
        chk("b2b_n",    32'(obs_n), 32'd8);
        chk("b2b_bits", 32'(obs[7:0]), 32'b1001_0110);

        // Load while busy is ignored
        obs = '0; obs_n = 0;
        cyc(1'b0, 1'b1, 4'b0001);
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 4'b1111);
        idle(5);
        chk("busy_n",    32'(obs_n), 32'd4);
        chk("busy_bits", 32'(obs[3:0]), 32'b0001);

        // Reset mid-word
        obs = '0; obs_n = 0;
        cyc(1'b0, 1'b1, 4'b1010);
        cyc(1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        idle(5);
        chk("rstmid_n",    32'(obs_n), 32'd2);
        chk("rstmid_bits", 32'(obs[1:0]), 32'b10);

        // Reset wins over a load at the same edge
        obs = '0; obs_n = 0;
        cyc(1'b1, 1'b1, 4'b1100);
        idle(5);
        chk("rstload_n", 32'(obs_n), 32'd0);

        // Random traffic
        for (int i = 0; i < 2000; i++)
            cyc(($urandom % 50) == 0, ($urandom % 3) != 0, W'($urandom));
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
